pixel_frame_writer: RTL and testbench
=====================================

Name: pixel_frame_writer

Overview:
- Write-side counterpart of the LED fetch path: accepts a raw byte stream of one 8x8 frame (3 bytes per pixel, host order) and packs it into 24-bit pixel words.
- Writes each word into the dual-port frame buffer at the physical LED slot for that logical pixel, so the output fetch side can read slots sequentially.
- Sits between the SPI/byte receiver and the frame buffer RAM write port. Signals frame completion.

Parameters:
- PIXEL_CNT, 64, pixels per frame; must equal 2^ADDR_W.
- ADDR_W, 6, frame buffer address width.
- ROW_LEN, 8, pixels per matrix row; power of two; used only by serpentine mapping.
- DATA_W, 24, pixel word width (3 x 8-bit).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- frame_start_in  in  1  one-cycle pulse; begins or restarts frame capture
- byte_valid_in  in  1  byte_data_in valid this cycle
- byte_data_in  in  8  stream byte
- byte_ready_out  out  1  high when a valid byte is consumed this cycle (state RECV)
- wr_en_out  out  1  frame buffer write strobe, one cycle per pixel
- wr_addr_out  out  ADDR_W  frame buffer write address
- wr_data_out  out  DATA_W  packed pixel {b0,b1,b2}, b0 in [23:16]
- busy_out  out  1  high in RECV
- frame_done_out  out  1  one-cycle pulse after the last pixel write

Behaviour:
- One clock; reset is synchronous and active-high on rst_in. All state updates on the rising clk_in edge.
- Reset values: state=IDLE, byte_cnt=0, pix_cnt=0, wr_en_out=0, wr_addr_out=0, wr_data_out=0, frame_done_out=0, busy_out=0. Reset overrides all other inputs in the same cycle.
- FSM states are IDLE, RECV and DONE.
- IDLE: bytes are dropped. frame_start_in moves to RECV and clears byte_cnt and pix_cnt.
- RECV: each byte_valid_in cycle consumes one byte.
  - byte_cnt 0 loads shift[23:16]; 1 loads shift[15:8].
  - 2 completes the pixel. Next cycle: wr_en_out=1, wr_data_out={shift[23:8],byte}, wr_addr_out=map(pix_cnt), byte_cnt returns to 0.
- Sustained throughput is 1 byte/cycle with no bubbles. The write strobe overlaps reception of the next pixel.
- On completion of pixel PIXEL_CNT-1, go to DONE. pix_cnt wraps to 0 and never exceeds PIXEL_CNT-1.
- DONE lasts one cycle. frame_done_out=1 in the cycle after the final wr_en_out pulse; then return to IDLE. Bytes arriving in DONE are dropped.
- frame_start_in in RECV or DONE restarts the frame: counters clear, partial pixel discarded, state=RECV.
  - A pixel completing in the same cycle is still written (its wr_en_out fires next cycle).
  - frame_start_in has priority over byte consumption in that cycle.
- wr_en_out and frame_done_out are single-cycle pulses. wr_addr_out and wr_data_out hold their last values when wr_en_out=0.
- byte_ready_out = byte_valid_in and (state==RECV) and not frame_start_in. It is combinational and for monitoring only; there is no backpressure.
- Default map(i)=i (linear).

Optional Feature:
- Macro LED_S_CURVE_EN.
- Defined: serpentine map. Odd rows (i / ROW_LEN odd) reverse their column bits: map(i) = {i[ADDR_W-1:log2 ROW_LEN], ~i[log2 ROW_LEN-1:0]}. Even rows are unchanged. This mapping is its own inverse. Example: 8->0x0F, 15->0x08, 16->0x10.
- Undefined: linear map(i)=i.
- Timing is identical in both builds.

Decomposition:
- Shared package/header holds PIXEL_CNT, ADDR_W, ROW_LEN, DATA_W and the state encodings (IDLE=2'd0, RECV=2'd1, DONE=2'd2).
- One natural sub-module, led_addr_map: purely combinational idx->addr mapping, containing the LED_S_CURVE_EN selection, reusable by the fetch side.

Test Plan:
- Reset held 3 cycles mid-RECV -> all outputs 0, state IDLE; bytes after release ignored until frame_start_in.
- frame_start then 192 back-to-back bytes 0x00..0xBF (linear) -> 64 writes; pixel k at addr k with data {3k,3k+1,3k+2}; frame_done_out exactly one cycle after the 64th wr_en_out.
- Same stream with LED_S_CURVE_EN -> pixel 8 data 0x18191A at addr 0x0F; pixel 15 at 0x08; pixel 63 at 0x38.
- Bytes with random byte_valid_in gaps (~50% duty) -> identical write contents/order as the gapless case; no write for partial pixels.
- frame_start after 4 bytes (pixel 0 written, 1 byte of pixel 1) then 192 bytes -> pixel 0 rewritten from the new stream, 64 total new writes, one frame_done.
- Bytes in IDLE and in the DONE cycle -> byte_ready_out=0, no writes, counters unchanged.

Source files
------------

// File: rtl/pixel_frame_writer_pkg.sv
// rtl/pixel_frame_writer_pkg.sv - shared geometry, state encoding and pixel packing helper
package pixel_frame_writer_pkg;

  localparam int PIXEL_CNT = 64;
  localparam int ADDR_W    = 6;
  localparam int ROW_LEN   = 8;
  localparam int DATA_W    = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  // First two bytes sit in the upper 16 bits, the closing byte in [7:0].
  function automatic logic [DATA_W-1:0] pack_pixel(input logic [15:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/pixel_frame_writer_if.sv
// rtl/pixel_frame_writer_if.sv - byte stream in, frame buffer write port and status out
interface pixel_frame_writer_if;
  import pixel_frame_writer_pkg::*;

  logic              frame_start_in;
  logic              byte_valid_in;
  logic [7:0]        byte_data_in;
  logic              byte_ready_out;
  logic              wr_en_out;
  logic [ADDR_W-1:0] wr_addr_out;
  logic [DATA_W-1:0] wr_data_out;
  logic              busy_out;
  logic              frame_done_out;

  // Host / byte receiver side.
  modport master (
    output frame_start_in, byte_valid_in, byte_data_in,
    input  byte_ready_out, wr_en_out, wr_addr_out, wr_data_out, busy_out, frame_done_out
  );

  // Writer side.
  modport slave (
    input  frame_start_in, byte_valid_in, byte_data_in,
    output byte_ready_out, wr_en_out, wr_addr_out, wr_data_out, busy_out, frame_done_out
  );

endinterface

// File: rtl/pixel_frame_writer_led_addr_map.sv
// rtl/pixel_frame_writer_led_addr_map.sv - logical pixel index to physical LED slot (LED_S_CURVE_EN selects serpentine)
module led_addr_map
  import pixel_frame_writer_pkg::*;
#(
  parameter int MAP_ADDR_W = ADDR_W
) (
  input  logic [MAP_ADDR_W-1:0] idx_i,
  output logic [MAP_ADDR_W-1:0] addr_o
);

`ifdef LED_S_CURVE_EN
  localparam int COL_W = $clog2(ROW_LEN);

  // Odd rows run right-to-left on the strip, so their column bits are mirrored.
  always_comb begin
    addr_o = idx_i;
    if (idx_i[COL_W]) begin
      addr_o = {idx_i[MAP_ADDR_W-1:COL_W], ~idx_i[COL_W-1:0]};
    end
  end
`else
  // Strip is wired in raster order.
  always_comb begin
    addr_o = idx_i;
  end
`endif

endmodule

// File: rtl/pixel_frame_writer.sv
// rtl/pixel_frame_writer.sv - packs a 3-byte-per-pixel stream into frame buffer writes (LED_S_CURVE_EN: serpentine slots)
module pixel_frame_writer
  import pixel_frame_writer_pkg::*;
(
  input  logic                clk_in,
  input  logic                rst_in,
  pixel_frame_writer_if.slave bus
);

  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXEL_CNT - 1);

  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [ADDR_W-1:0] pix_cnt_q;
  logic [15:0]       shift_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              frame_done_q;
  logic [ADDR_W-1:0] slot_addr;

  led_addr_map #(.MAP_ADDR_W(ADDR_W)) u_map (
    .idx_i  (pix_cnt_q),
    .addr_o (slot_addr)
  );

  // Capture FSM: byte assembly, pixel write strobe and frame completion pulse.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      byte_cnt_q   <= 2'd0;
      pix_cnt_q    <= '0;
      shift_q      <= 16'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      wr_en_q      <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.frame_start_in) begin
            state_q    <= RECV;
            byte_cnt_q <= 2'd0;
            pix_cnt_q  <= '0;
          end
        end
        RECV: begin
          // A pixel that closes on a restart cycle is still committed.
          if (bus.byte_valid_in && byte_cnt_q == 2'd2) begin
            wr_en_q   <= 1'b1;
            wr_data_q <= pack_pixel(shift_q, bus.byte_data_in);
            wr_addr_q <= slot_addr;
          end
          if (bus.frame_start_in) begin
            byte_cnt_q <= 2'd0;
            pix_cnt_q  <= '0;
          end else if (bus.byte_valid_in) begin
            case (byte_cnt_q)
              2'd0: begin
                shift_q[15:8] <= bus.byte_data_in;
                byte_cnt_q    <= 2'd1;
              end
              2'd1: begin
                shift_q[7:0] <= bus.byte_data_in;
                byte_cnt_q   <= 2'd2;
              end
              default: begin
                byte_cnt_q <= 2'd0;
                if (pix_cnt_q == LAST_PIX) begin
                  pix_cnt_q <= '0;
                  state_q   <= DONE;
                end else begin
                  pix_cnt_q <= pix_cnt_q + 1'b1;
                end
              end
            endcase
          end
        end
        DONE: begin
          frame_done_q <= 1'b1;
          if (bus.frame_start_in) begin
            state_q    <= RECV;
            byte_cnt_q <= 2'd0;
            pix_cnt_q  <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.byte_ready_out = bus.byte_valid_in && (state_q == RECV) && !bus.frame_start_in;
  assign bus.busy_out       = (state_q == RECV);
  assign bus.wr_en_out      = wr_en_q;
  assign bus.wr_addr_out    = wr_addr_q;
  assign bus.wr_data_out    = wr_data_q;
  assign bus.frame_done_out = frame_done_q;

endmodule

// File: tb/tb_pixel_frame_writer.sv
// tb/tb_pixel_frame_writer.sv - randomized self-checking bench for pixel_frame_writer (LED_S_CURVE_EN aware)
module tb_pixel_frame_writer;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   last_byte_cyc = 0;

  logic [29:0] wq[$];
  int          wr_cycles[$];
  int          done_cycles[$];
  logic [7:0]  strm[192];
  logic [7:0]  old_b[4];

  always #5 clk = ~clk;

  pixel_frame_writer_if bus();

  pixel_frame_writer dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus.slave)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port and completion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.wr_en_out) begin
      wq.push_back({bus.wr_addr_out, bus.wr_data_out});
      wr_cycles.push_back(cyc);
    end
    if (bus.frame_done_out) done_cycles.push_back(cyc);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Physical slot of logical pixel k, from row/column geometry.
  function automatic logic [5:0] ref_map(input int k);
    int row;
    int col;
    row = k / 8;
    col = k % 8;
`ifdef LED_S_CURVE_EN
    if (row % 2 == 1) return 6'(row * 8 + (7 - col));
`endif
    return 6'(row * 8 + col);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    wr_cycles.delete();
    done_cycles.delete();
  endtask

  task automatic start_frame();
    bus.frame_start_in = 1'b1;
    bus.byte_valid_in  = 1'b0;
    tick();
    bus.frame_start_in = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ready, input string tag);
    bus.byte_valid_in = 1'b1;
    bus.byte_data_in  = b;
    #1;
    check(tag, 64'(bus.byte_ready_out), 64'(exp_ready));
    last_byte_cyc = cyc;
    tick();
    bus.byte_valid_in = 1'b0;
  endtask

  task automatic send_stream(input bit gaps);
    for (int i = 0; i < 192; i++) begin
      while (gaps && $urandom_range(1, 0) == 1) begin
        bus.byte_valid_in = 1'b0;
        bus.byte_data_in  = 8'($urandom);
        tick();
      end
      send_byte(strm[i], 1'b1, "ready_recv");
    end
  endtask

  task automatic idle(input int n);
    bus.byte_valid_in = 1'b0;
    repeat (n) tick();
  endtask

  // Compare 64 logged writes starting at base with the reference frame.
  task automatic check_frame(input int base);
    check("write_count", 64'(wq.size()), 64'(base + 64));
    for (int k = 0; k < 64; k++) begin
      if (base + k < wq.size())
        check("pixel", 64'(wq[base + k]), 64'({ref_map(k), strm[3*k], strm[3*k+1], strm[3*k+2]}));
    end
    check("done_count", 64'(done_cycles.size()), 64'd1);
    if (wr_cycles.size() > 0) begin
      check("last_wr_latency", 64'(wr_cycles[wr_cycles.size()-1]), 64'(last_byte_cyc + 1));
      if (done_cycles.size() > 0)
        check("done_after_last_wr", 64'(done_cycles[0]), 64'(wr_cycles[wr_cycles.size()-1] + 1));
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.frame_start_in = 1'b0;
    bus.byte_valid_in  = 1'b0;
    bus.byte_data_in   = 8'h00;
    repeat (2) tick();
    rst = 1'b0;

    // Reset asserted for three cycles in the middle of a frame.
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(8'($urandom) | 8'h01, 1'b1, "ready_pre_reset");
    rst = 1'b1;
    repeat (3) tick();
    check("rst_wr_en", 64'(bus.wr_en_out), 64'd0);
    check("rst_wr_addr", 64'(bus.wr_addr_out), 64'd0);
    check("rst_wr_data", 64'(bus.wr_data_out), 64'd0);
    check("rst_done", 64'(bus.frame_done_out), 64'd0);
    check("rst_busy", 64'(bus.busy_out), 64'd0);
    rst = 1'b0;
    clear_log();

    // Bytes in IDLE are dropped.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, "ready_idle");
    idle(3);
    check("idle_writes", 64'(wq.size()), 64'd0);
    check("idle_busy", 64'(bus.busy_out), 64'd0);

    // Gapless counting frame.
    for (int i = 0; i < 192; i++) strm[i] = 8'(i);
    clear_log();
    start_frame();
    check("busy_recv", 64'(bus.busy_out), 64'd1);
    send_stream(1'b0);
    idle(4);
    check_frame(0);

    // Random bytes with random gaps, then bytes in the DONE cycle and after.
    for (int i = 0; i < 192; i++) strm[i] = 8'($urandom);
    clear_log();
    start_frame();
    send_stream(1'b1);
    begin
      int saved_cyc;
      saved_cyc = last_byte_cyc;
      send_byte(8'($urandom), 1'b0, "ready_done");
      send_byte(8'($urandom), 1'b0, "ready_after_done");
      send_byte(8'($urandom), 1'b0, "ready_after_done");
      last_byte_cyc = saved_cyc;
    end
    idle(3);
    check_frame(0);
    check("busy_after_frame", 64'(bus.busy_out), 64'd0);

    // Restart after four bytes: old pixel 0 written, partial pixel discarded.
    for (int i = 0; i < 4; i++) old_b[i] = 8'($urandom);
    for (int i = 0; i < 192; i++) strm[i] = 8'($urandom);
    clear_log();
    start_frame();
    for (int i = 0; i < 4; i++) send_byte(old_b[i], 1'b1, "ready_partial");
    start_frame();
    send_stream(1'b1);
    idle(4);
    if (wq.size() > 0)
      check("old_pixel0", 64'(wq[0]), 64'({ref_map(0), old_b[0], old_b[1], old_b[2]}));
    else
      check("old_pixel0_present", 64'd0, 64'd1);
    check_frame(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
